// File: rtl/jam_cost_server_if.sv
// Bundle between the cost server, its matrix-load source and the assignment engine.
// The master side drives the load words, the W/J read address and the result strobe.
interface jam_cost_server_if #(
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
);
  logic              load_valid;
  logic [COST_W-1:0] load_data;
  logic              load_ready;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              jam_rst;
  logic              Valid;
  logic [9:0]        MinCost;
  logic [3:0]        MatchCount;
  logic              done;
  logic [9:0]        res_min_cost;
  logic [3:0]        res_match;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output load_valid, load_data, W, J, Valid, MinCost, MatchCount,
    input  load_ready, Cost, jam_rst, done, res_min_cost, res_match, cycle_count
  );

  modport slave (
    input  load_valid, load_data, W, J, Valid, MinCost, MatchCount,
    output load_ready, Cost, jam_rst, done, res_min_cost, res_match, cycle_count
  );
endinterface

// File: rtl/jam_cost_server.sv
// Holds the 8x8 cost matrix, serves zero-latency W/J reads, keeps the engine in reset
// until all 64 words are loaded, then captures the engine result and times the search.
module jam_cost_server #(
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  jam_cost_server_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        ptr_q, ptr_d;
  logic              mem_we;
  logic [COST_W-1:0] mem_q [64];
  logic              jam_rst_q, jam_rst_d;
  logic              done_q, done_d;
  logic [9:0]        min_q, min_d;
  logic [3:0]        match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    done_d  = done_q;
    min_d   = min_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 6'd1;
          if (ptr_q == 6'd63) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The cycle that samples Valid is still counted.
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bus.Valid) begin
          min_d   = bus.MinCost;
          match_d = bus.MatchCount;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_LOAD;
    endcase
    jam_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_LOAD;
      ptr_q     <= 6'd0;
      jam_rst_q <= 1'b1;
      done_q    <= 1'b0;
      min_q     <= 10'd0;
      match_q   <= 4'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      jam_rst_q <= jam_rst_d;
      done_q    <= done_d;
      min_q     <= min_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  // Matrix storage is deliberately not reset; a full reload always precedes use.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[ptr_q] <= bus.load_data;
  end

  assign bus.load_ready   = (state_q == ST_LOAD);
  assign bus.Cost         = (state_q == ST_LOAD) ? '0 : mem_q[{bus.W, bus.J}];
  assign bus.jam_rst      = jam_rst_q;
  assign bus.done         = done_q;
  assign bus.res_min_cost = min_q;
  assign bus.res_match    = match_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: read vectors from a table, multi-cycle
// sequences for load gaps, mid-load reset, result capture and counter saturation.
module tb_jam_cost_server;

  localparam int COST_W = 7;
  localparam int CNT_W  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  jam_cost_server_if #(.COST_W(COST_W), .CNT_W(CNT_W)) bus ();

  jam_cost_server #(.COST_W(COST_W), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ph;
    int w;
    int j;
    int exp_cost;
  } rd_vec_t;

  rd_vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reads(input int ph);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ph == ph) begin
        bus.W = vecs[i].w[2:0];
        bus.J = vecs[i].j[2:0];
        #1;
        chk($sformatf("cost_p%0d_w%0d_j%0d", ph, vecs[i].w, vecs[i].j),
            int'(bus.Cost), vecs[i].exp_cost);
      end
    end
  endtask

  // Asserts RST mid-cycle and checks the outputs react without waiting for an edge.
  task automatic mid_reset(input string tag);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    bus.W = 3'd5;
    bus.J = 3'd3;
    #1;
    chk({tag, "_load_ready"}, int'(bus.load_ready), 1);
    chk({tag, "_jam_rst"}, int'(bus.jam_rst), 1);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_cycle_count"}, int'(bus.cycle_count), 0);
    chk({tag, "_cost"}, int'(bus.Cost), 0);
    #2;
    RST = 1'b0;
    tick();
  endtask

  initial begin
    int idx;

    vecs[0] = '{1, 5, 3, 43};
    vecs[1] = '{1, 7, 7, 63};
    vecs[2] = '{1, 0, 0, 0};
    vecs[3] = '{1, 2, 6, 22};
    vecs[4] = '{1, 7, 0, 56};
    vecs[5] = '{2, 5, 3, 43};
    vecs[6] = '{2, 0, 7, 7};
    vecs[7] = '{3, 5, 3, 84};
    vecs[8] = '{3, 0, 0, 127};
    vecs[9] = '{3, 7, 7, 64};

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.W          = 3'd0;
    bus.J          = 3'd0;
    bus.Valid      = 1'b0;
    bus.MinCost    = 10'd0;
    bus.MatchCount = 4'd0;

    tick();
    mid_reset("rst0");
    chk("rst0_res_min", int'(bus.res_min_cost), 0);
    chk("rst0_res_match", int'(bus.res_match), 0);

    // Partial load of 30 junk words, then reset: a full reload must follow.
    for (int i = 0; i < 30; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 7'd100;
      tick();
    end
    bus.load_valid = 1'b0;
    chk("partial_jam_rst", int'(bus.jam_rst), 1);
    mid_reset("rst_mid");

    // Gapped load: idle on every third cycle, last word lands on cycle 95.
    idx = 0;
    for (int c = 0; c < 96; c++) begin
      if (c % 3 == 0) begin
        bus.load_valid = 1'b0;
        bus.load_data  = 7'h7f;
      end else begin
        bus.load_valid = 1'b1;
        bus.load_data  = idx[COST_W-1:0];
        idx = idx + 1;
      end
      if (c == 95) begin
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd7;
        bus.MatchCount = 4'd9;
        #1;
        chk("pre_last_ready", int'(bus.load_ready), 1);
        chk("pre_last_jam_rst", int'(bus.jam_rst), 1);
      end
      tick();
      if (c == 94) chk("gap_ready_held", int'(bus.load_ready), 1);
    end
    bus.load_valid = 1'b0;
    bus.Valid      = 1'b0;
    chk("run_load_ready", int'(bus.load_ready), 0);
    chk("run_jam_rst", int'(bus.jam_rst), 0);
    chk("edge_valid_ignored", int'(bus.done), 0);
    chk("run_count_start", int'(bus.cycle_count), 0);
    do_reads(1);

    // Valid in the 100th RUN cycle.
    for (int i = 1; i < 100; i++) tick();
    chk("count_before_valid", int'(bus.cycle_count), 99);
    bus.Valid      = 1'b1;
    bus.MinCost    = 10'd300;
    bus.MatchCount = 4'd2;
    tick();
    bus.Valid = 1'b0;
    chk("cap_done", int'(bus.done), 1);
    chk("cap_min", int'(bus.res_min_cost), 300);
    chk("cap_match", int'(bus.res_match), 2);
    chk("cap_count", int'(bus.cycle_count), 100);
    chk("cap_jam_rst", int'(bus.jam_rst), 1);

    bus.Valid      = 1'b1;
    bus.MinCost    = 10'd5;
    bus.MatchCount = 4'd1;
    tick();
    bus.Valid = 1'b0;
    tick();
    chk("done_hold_min", int'(bus.res_min_cost), 300);
    chk("done_hold_match", int'(bus.res_match), 2);
    chk("done_hold_count", int'(bus.cycle_count), 100);
    chk("done_hold_done", int'(bus.done), 1);
    do_reads(2);

    // Reset out of DONE, contiguous reload with new values.
    mid_reset("rst_done");
    for (int i = 0; i < 64; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 7'(127 - i);
      tick();
      if (i == 62) chk("reload_jam_rst_63", int'(bus.jam_rst), 1);
    end
    chk("reload_jam_rst", int'(bus.jam_rst), 0);

    // Load words presented in RUN must not touch the matrix.
    bus.load_data = 7'd0;
    for (int i = 0; i < 10; i++) tick();
    bus.load_valid = 1'b0;
    do_reads(3);

    for (int i = 0; i < 70000; i++) tick();
    chk("sat_count", int'(bus.cycle_count), 65535);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", int'(bus.cycle_count), 65535);
    chk("sat_done", int'(bus.done), 0);
    chk("sat_jam_rst", int'(bus.jam_rst), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
